// File: rtl/spi_slave_pkg.sv
// Shared types and command encodings for the SPI slave front end.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // True when cmd is a legal command for a frame received in state st.
  function automatic logic cmd_legal(input state_e st, input logic [1:0] cmd);
    case (st)
      WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      READ_ADD:  return cmd == CMD_RD_ADDR;
      READ_DATA: return cmd == CMD_RD_DATA;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO read-data serialiser: once armed, captures tx_data on the first
// tx_valid and shifts it out MSB first. abort (SS_n high) clears everything.
// Optional macro SPI_SLAVE_TX_TIMEOUT_EN: give up after TX_TIMEOUT cycles
// without tx_valid and raise a one-cycle tmo strobe.
module spi_tx_shifter #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
  output logic              tmo
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  if (TX_TIMEOUT < 1 || DATA_W < 2) begin : g_bad_param
    $error("spi_tx_shifter: TX_TIMEOUT must be >= 1 and DATA_W >= 2");
  end

  logic              waiting;
  logic              sending;
  logic [DATA_W-1:0] sh;
  logic [BIT_W-1:0]  left;

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TX_TIMEOUT + 1);
  logic [TMR_W-1:0] timer;

  // Timeout strobe on the last waiting cycle without tx_valid.
  always_comb begin
    tmo = waiting && !abort && !arm && !tx_valid && (timer == TMR_W'(TX_TIMEOUT - 1));
  end
`else
  // Without the timeout the block waits for tx_valid indefinitely.
  always_comb begin
    tmo = 1'b0;
  end
`endif

  // Arm -> wait for tx_valid -> shift DATA_W bits out, then idle with MISO low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting <= 1'b0;
      sending <= 1'b0;
      sh      <= '0;
      left    <= '0;
      miso    <= 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
      timer   <= '0;
`endif
    end else if (abort) begin
      waiting <= 1'b0;
      sending <= 1'b0;
      sh      <= '0;
      left    <= '0;
      miso    <= 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
      timer   <= '0;
`endif
    end else if (arm) begin
      waiting <= 1'b1;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
      timer   <= '0;
`endif
    end else if (waiting) begin
      if (tx_valid) begin
        // MSB goes straight to MISO; the rest wait in sh.
        waiting <= 1'b0;
        sending <= 1'b1;
        miso    <= tx_data[DATA_W-1];
        sh      <= tx_data << 1;
        left    <= BIT_W'(DATA_W - 1);
      end
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
      else if (tmo) begin
        waiting <= 1'b0;
      end else begin
        timer <= timer + TMR_W'(1);
      end
`endif
    end else if (sending) begin
      if (left != '0) begin
        miso <= sh[DATA_W-1];
        sh   <= sh << 1;
        left <= left - BIT_W'(1);
      end else begin
        miso    <= 1'b0;
        sending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front end: deserialises {cmd, payload} frames,
// flags illegal commands and serialises RAM read data on MISO.
// Optional macro SPI_SLAVE_TX_TIMEOUT_EN enables the tx_valid timeout.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  state_e             state;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic               done;
  logic               rd_pending;
  logic               frame_ready;
  logic               frame_ok;
  logic               tx_arm;
  logic               tx_tmo;

  // Frame completion detect and command legality for the current state.
  always_comb begin
    frame_ready = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA)) &&
                  (cnt == CNT_W'(FRAME_W)) && !done;
    frame_ok    = cmd_legal(state, shreg[FRAME_W-1 -: 2]);
    tx_arm      = !SS_n && frame_ready && frame_ok && (state == READ_DATA);
  end

  // Main FSM: routing, bit collection, frame check and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      rd_pending <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= tx_tmo;
      if (SS_n) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
        done  <= 1'b0;
      end else begin
        busy <= 1'b1;
        case (state)
          IDLE: begin
            state <= CHK_CMD;
            cnt   <= '0;
            done  <= 1'b0;
          end
          CHK_CMD: begin
            if (!MOSI)          state <= WRITE;
            else if (rd_pending) state <= READ_DATA;
            else                state <= READ_ADD;
          end
          default: begin
            // Counter saturates at FRAME_W; done blocks a second check.
            if (frame_ready) begin
              done <= 1'b1;
              if (frame_ok) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (state == READ_ADD)       rd_pending <= 1'b1;
                else if (state == READ_DATA) rd_pending <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (cnt != CNT_W'(FRAME_W)) begin
              shreg <= {shreg[FRAME_W-2:0], MOSI};
              cnt   <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  spi_tx_shifter #(
    .DATA_W     (DATA_W),
    .TX_TIMEOUT (TX_TIMEOUT)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (tx_arm),
    .abort    (SS_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .miso     (MISO),
    .tmo      (tx_tmo)
  );

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param (DATA_W=8 and DATA_W=16 instances).
module tb_spi_slave_param;
  import spi_slave_pkg::*;

  localparam int KIND_RXV  = 0;
  localparam int KIND_FERR = 1;

  typedef struct {
    int          unit;
    int          kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  typedef struct {
    logic b;
    int   cyc;
  } mb_t;

  ev_t evq[$];
  mb_t mq[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SS_n2, MOSI;
  logic        MISO, MISO2;
  logic [9:0]  rx_data;
  logic [17:0] rx_data2;
  logic        rx_valid, rx_valid2;
  logic [7:0]  tx_data;
  logic [15:0] tx_data2;
  logic        tx_valid, tx_valid2;
  logic        frame_err, frame_err2;
  logic        busy, busy2;

  spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n2), .MOSI(MOSI), .MISO(MISO2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .frame_err(frame_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_event(input int unit, input int kind, input logic [31:0] data);
    ev_t e;
    if (evq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got unit %0d kind %0d data %0h at cycle %0d, required none",
               unit, kind, data, cyc);
    end else begin
      e = evq.pop_front();
      chk("ev_unit", unit, e.unit);
      chk("ev_kind", kind, e.kind);
      chk("ev_data", data, e.data);
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: pops expected events on every output pulse, checks MISO each cycle.
  always @(negedge clk) begin
    logic exp_m;
    if (rx_valid)   pop_event(1, KIND_RXV, 32'(rx_data));
    if (frame_err)  pop_event(1, KIND_FERR, 32'h0);
    if (rx_valid2)  pop_event(2, KIND_RXV, 32'(rx_data2));
    if (frame_err2) pop_event(2, KIND_FERR, 32'h0);
    exp_m = 1'b0;
    if (mq.size() != 0 && mq[0].cyc < cyc) begin
      chk("miso_missed_slot", cyc, mq[0].cyc);
      void'(mq.pop_front());
    end
    if (mq.size() != 0 && mq[0].cyc == cyc) exp_m = mq.pop_front().b;
    chk("miso", MISO, exp_m);
    chk("miso2", MISO2, 1'b0);
  end

  task automatic expect_ev(input int unit, input int kind, input logic [31:0] data, input int c);
    ev_t e;
    e.unit = unit; e.kind = kind; e.data = data; e.cyc = c;
    evq.push_back(e);
  endtask

  task automatic expect_miso(input logic [7:0] d, input int c0);
    mb_t m;
    for (int i = 0; i < 8; i++) begin
      m.b   = d[7-i];
      m.cyc = c0 + i;
      mq.push_back(m);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int unit, input logic route, input logic [31:0] frame,
                           input int fw, input int extra);
    if (unit == 1) SS_n = 1'b0; else SS_n2 = 1'b0;
    tick();
    MOSI = route;
    tick();
    for (int i = fw - 1; i >= 0; i--) begin
      MOSI = frame[i];
      tick();
    end
    MOSI = 1'b1;
    for (int i = 0; i < extra; i++) tick();
    MOSI = 1'b0;
  endtask

  task automatic end_frame();
    SS_n  = 1'b1;
    SS_n2 = 1'b1;
    MOSI  = 1'b0;
    tick();
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; SS_n = 1'b1; SS_n2 = 1'b1; MOSI = 1'b0;
    tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    repeat (2) tick();
    chk("rst_miso", MISO, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_pending", dut.rd_pending, 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // Write address frame 00_1010_0101, extra bits ignored.
    n0 = cyc;
    expect_ev(1, KIND_RXV, 32'h0A5, n0 + 13);
    run_frame(1, 1'b0, 32'h0A5, 10, 3);
    chk("wr_busy", busy, 1);
    end_frame();
    chk("wr_busy_idle", busy, 0);
    chk("wr_rd_pending", dut.rd_pending, 0);

    // Read address frame sets rd_pending.
    n0 = cyc;
    expect_ev(1, KIND_RXV, 32'h203, n0 + 13);
    run_frame(1, 1'b1, 32'h203, 10, 0);
    tick();
    chk("rda_rd_pending", dut.rd_pending, 1);
    end_frame();

    // Read data frame; tx_valid held during the frame must be ignored.
    n0 = cyc;
    expect_ev(1, KIND_RXV, 32'h300, n0 + 13);
    tx_valid = 1'b1; tx_data = 8'hFF;
    run_frame(1, 1'b1, 32'h300, 10, 0);
    tick();
    tx_valid = 1'b0;
    chk("rdd_rd_pending", dut.rd_pending, 0);
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    expect_ev(1, KIND_FERR, 32'h0, n0 + 29);
`else
    expect_miso(8'hC3, n0 + 34);
`endif
    repeat (20) tick();
    tx_valid = 1'b1; tx_data = 8'hC3;
    tick();
    tx_valid = 1'b0; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (8) tick();
    end_frame();

    // Abort after 5 payload bits.
    run_frame(1, 1'b0, 32'h15, 5, 0);
    end_frame();
    chk("abort_busy", busy, 0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_rx_data", rx_data, 10'h300);
    repeat (12) tick();

    // Illegal command on the write route.
    n0 = cyc;
    expect_ev(1, KIND_FERR, 32'h0, n0 + 13);
    run_frame(1, 1'b0, 32'h2F0, 10, 2);
    chk("ill_rx_data", rx_data, 10'h300);
    chk("ill_rd_pending", dut.rd_pending, 0);
    end_frame();

    // Reset asserted mid MISO shifting.
    n0 = cyc;
    expect_ev(1, KIND_RXV, 32'h203, n0 + 13);
    run_frame(1, 1'b1, 32'h203, 10, 0);
    tick();
    end_frame();
    n0 = cyc;
    expect_ev(1, KIND_RXV, 32'h300, n0 + 13);
    run_frame(1, 1'b1, 32'h300, 10, 0);
    tick();
    tx_valid = 1'b1; tx_data = 8'hC3;
    begin
      mb_t m;
      m.b = 1'b1; m.cyc = n0 + 14;
      mq.push_back(m);
    end
    tick();
    tx_valid = 1'b0;
    tick();
    chk("pre_reset_miso", MISO, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_miso", MISO, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rx_data", rx_data, 0);
    chk("async_rst_rd_pending", dut.rd_pending, 0);
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    SS_n = 1'b0;
    tick();
    MOSI = 1'b1;
    tick();
    chk("post_rst_state", 32'(dut.state), 32'(READ_ADD));
    chk("post_rst_busy", busy, 1);
    end_frame();

    // DATA_W=16 write frame 01_BEEF.
    n0 = cyc;
    expect_ev(2, KIND_RXV, 32'h1BEEF, n0 + 21);
    run_frame(2, 1'b0, 32'h1BEEF, 18, 1);
    chk("w16_busy", busy2, 1);
    end_frame();
    chk("w16_busy_idle", busy2, 0);
    repeat (4) tick();

    chk("events_pending", evq.size(), 0);
    chk("miso_pending", mq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
